// File: rtl/instruction_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: bus widths, FSM states and FIFO entry.
package instruction_fetch_ctrl_pkg;

    typedef logic [31:0] word_t;
    typedef logic [15:0] half_word_t;

    typedef enum logic [1:0] {
        StReset,
        StRun,
        StHalted
    } fetch_state_t;

    localparam word_t FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        word_t      pc;
        half_word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_ctrl_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr}; flush beats push and pop.
module instruction_fetch_ctrl_fetch_fifo
    import instruction_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           push_i,
    input  fetch_entry_t                   entry_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output logic [$clog2(DEPTH + 1)-1:0]   count_o,
    output fetch_entry_t                   head_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PtrW-1:0] ptr_t;

    // Explicit wrap so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = entry_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Fetch controller: drives the PC into a one-cycle-latency instruction memory, tracks the
// single outstanding read and buffers responses for decode. Handles branch redirect and halt.
module instruction_fetch_ctrl
    import instruction_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter word_t       RESET_PC = FETCH_RESET_PC
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    output word_t      mem_pc_o,
    input  half_word_t mem_instr_i,
    output half_word_t instr_o,
    output word_t      instr_pc_o,
    output logic       instr_valid_o,
    input  logic       decode_ready_i,
    input  logic       branch_valid_i,
    input  word_t      branch_target_i,
    input  logic       halt_i,
    output logic       halted_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_t    state_q, state_d;
    word_t           fetch_pc_q, fetch_pc_d;
    word_t           last_pc_q, last_pc_d;
    word_t           inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;

    logic [CntW-1:0] count;
    fetch_entry_t    head;
    logic            branch, pop, push, issue, launch;
    word_t           target, occupancy, launch_pc;

    assign branch        = branch_valid_i && (state_q != StReset);
    assign target        = {branch_target_i[31:1], 1'b0};
    assign instr_valid_o = (count != '0) && (state_q != StReset);
    assign pop           = instr_valid_o && decode_ready_i && !branch;
    // A branch kills the returning read by simply not writing it.
    assign push          = inflight_q && !branch;
    // Slots that would be committed after this edge if nothing new were issued.
    assign occupancy     = 32'(count) + 32'(inflight_q) - 32'(pop);
    assign issue         = (state_q == StRun) && !halt_i && !branch && (occupancy < DEPTH);
    assign launch        = branch || issue;
    assign launch_pc     = branch ? target : fetch_pc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StRun;
            StRun:    if (halt_i) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StReset;
        endcase
        if (branch) begin
            state_d = StRun;
        end

        mem_pc_o      = last_pc_q;
        fetch_pc_d    = fetch_pc_q;
        last_pc_d     = last_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (launch) begin
            mem_pc_o      = launch_pc;
            fetch_pc_d    = launch_pc + 32'd2;
            last_pc_d     = launch_pc;
            inflight_pc_d = launch_pc;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= StReset;
            fetch_pc_q    <= RESET_PC;
            last_pc_q     <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            last_pc_q     <= last_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    instruction_fetch_ctrl_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .entry_i   ('{pc: inflight_pc_q, instr: mem_instr_i}),
        .pop_i     (pop),
        .flush_i   (branch),
        .count_o   (count),
        .head_o    (head)
    );

    assign instr_o    = head.instr;
    assign instr_pc_o = head.pc;
    assign halted_o   = (state_q == StHalted);

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(push && !pop && (32'(count) == DEPTH)));
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl: directed steps plus a randomized phase, checked against a
// program-order stream model (expected next PC, memory contents, halt flag).
module tb_instruction_fetch_ctrl;
    import instruction_fetch_ctrl_pkg::*;

    localparam int unsigned D1 = 2;
    localparam word_t       R1 = 32'h0000_0000;
    localparam int unsigned D2 = 3;
    localparam word_t       R2 = 32'hFFFF_FFFC;

    logic       clk = 1'b0;
    logic       reset_n;
    word_t      mem_pc1, instr_pc1, target;
    half_word_t mem_instr1, instr1;
    logic       valid1, ready1, branch, halt, halted1;
    word_t      mem_pc2, instr_pc2;
    half_word_t mem_instr2, instr2;
    logic       valid2, ready2, halted2;

    int compared = 0;
    int mismatched = 0;
    int pops2 = 0;

    word_t exp1, exp2, held_pc, held_mem;
    bit    mh, in_rst, brp;

    always #5 clk = ~clk;

    instruction_fetch_ctrl #(.DEPTH(D1), .RESET_PC(R1)) dut1 (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .mem_pc_o       (mem_pc1),
        .mem_instr_i    (mem_instr1),
        .instr_o        (instr1),
        .instr_pc_o     (instr_pc1),
        .instr_valid_o  (valid1),
        .decode_ready_i (ready1),
        .branch_valid_i (branch),
        .branch_target_i(target),
        .halt_i         (halt),
        .halted_o       (halted1)
    );

    instruction_fetch_ctrl #(.DEPTH(D2), .RESET_PC(R2)) dut2 (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .mem_pc_o       (mem_pc2),
        .mem_instr_i    (mem_instr2),
        .instr_o        (instr2),
        .instr_pc_o     (instr_pc2),
        .instr_valid_o  (valid2),
        .decode_ready_i (ready2),
        .branch_valid_i (1'b0),
        .branch_target_i(32'h0),
        .halt_i         (1'b0),
        .halted_o       (halted2)
    );

    function automatic half_word_t mem_val(input word_t a);
        case (a)
            32'h0:   return 16'h1111;
            32'h2:   return 16'h2222;
            32'h4:   return 16'h3333;
            default: return a[15:0] ^ a[31:16] ^ 16'hBEEF;
        endcase
    endfunction

    // Synchronous-read instruction memories.
    always @(posedge clk) begin
        mem_instr1 <= mem_val(mem_pc1);
        mem_instr2 <= mem_val(mem_pc2);
    end

    task automatic chk(input string tag, input word_t got, input word_t exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Checks accepted instructions before the edge, advances one cycle, returns at negedge.
    task automatic cycle();
        #2;
        brp = branch && reset_n;
        if (!reset_n) begin
            exp1   = R1;
            exp2   = R2;
            mh     = 1'b0;
            in_rst = 1'b1;
        end else begin
            if (branch && !in_rst) begin
                exp1 = target & ~32'h1;
                mh   = 1'b0;
            end else begin
                if (valid1 && ready1) begin
                    chk("pop1_pc", instr_pc1, exp1);
                    chk("pop1_instr", 32'(instr1), 32'(mem_val(exp1)));
                    exp1 = exp1 + 32'd2;
                end
                if (halt && !in_rst) mh = 1'b1;
            end
            in_rst = 1'b0;
            if (valid2 && ready2) begin
                chk("pop2_pc", instr_pc2, exp2);
                chk("pop2_instr", 32'(instr2), 32'(mem_val(exp2)));
                exp2  = exp2 + 32'd2;
                pops2++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        ready2 = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        reset_n = 1'b0;
        ready1  = 1'b1;
        ready2  = 1'b1;
        branch  = 1'b0;
        halt    = 1'b0;
        target  = '0;
        exp1    = R1;
        exp2    = R2;
        mh      = 1'b0;
        in_rst  = 1'b1;
        brp     = 1'b0;

        repeat (3) cycle();
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_instr", 32'(instr1), 32'd0);
        chk("rst_instr_pc", instr_pc1, 32'd0);
        chk("rst_halted", 32'(halted1), 32'd0);
        chk("rst_mem_pc", mem_pc1, R1);
        chk("rst_mem_pc2", mem_pc2, R2);

        // Cold start latency.
        reset_n = 1'b1;
        cycle();
        chk("e0_valid", 32'(valid1), 32'd0);
        chk("e0_issue", mem_pc1, R1);
        cycle();
        chk("e1_valid", 32'(valid1), 32'd0);
        chk("e1_issue", mem_pc1, 32'd2);
        cycle();
        chk("e2_valid", 32'(valid1), 32'd1);
        chk("e2_instr", 32'(instr1), 32'h1111);
        cycle();
        chk("seq2_pc", instr_pc1, 32'd2);
        chk("seq2_instr", 32'(instr1), 32'h2222);
        cycle();
        chk("seq3_pc", instr_pc1, 32'd4);
        chk("seq3_instr", 32'(instr1), 32'h3333);
        repeat (3) cycle();

        // Backpressure: head holds, no new issues, no gap on resume.
        ready1 = 1'b0;
        cycle();
        held_pc  = instr_pc1;
        held_mem = mem_pc1;
        repeat (4) begin
            cycle();
            chk("stall_valid", 32'(valid1), 32'd1);
            chk("stall_head", instr_pc1, held_pc);
            chk("stall_no_issue", mem_pc1, held_mem);
        end
        ready1 = 1'b1;
        repeat (4) begin
            cycle();
            chk("resume_valid", 32'(valid1), 32'd1);
        end

        // Branch with a read in flight.
        branch = 1'b1;
        target = 32'h0000_0101;
        #1;
        chk("br_mem_pc", mem_pc1, 32'h0000_0100);
        cycle();
        branch = 1'b0;
        chk("br_t1_valid", 32'(valid1), 32'd0);
        cycle();
        chk("br_t2_valid", 32'(valid1), 32'd1);
        chk("br_t2_pc", instr_pc1, 32'h0000_0100);

        // Branch plus pop with a full FIFO.
        ready1 = 1'b0;
        repeat (3) cycle();
        ready1 = 1'b1;
        branch = 1'b1;
        target = 32'h0000_2000;
        cycle();
        branch = 1'b0;
        chk("brfull_t1_valid", 32'(valid1), 32'd0);
        cycle();
        chk("brfull_t2_pc", instr_pc1, 32'h0000_2000);
        repeat (2) cycle();

        // Halt, drain, resume by branch.
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        chk("halt_flag", 32'(halted1), 32'd1);
        held_mem = mem_pc1;
        repeat (4) begin
            cycle();
            chk("halt_no_issue", mem_pc1, held_mem);
        end
        chk("halt_drained", 32'(valid1), 32'd0);
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        chk("halt_in_halted", 32'(halted1), 32'd1);
        branch = 1'b1;
        target = 32'h0000_0040;
        cycle();
        branch = 1'b0;
        chk("resume_halted", 32'(halted1), 32'd0);
        chk("resume_t1_valid", 32'(valid1), 32'd0);
        cycle();
        chk("resume_t2_pc", instr_pc1, 32'h0000_0040);
        halt   = 1'b1;
        branch = 1'b1;
        target = 32'h0000_0080;
        cycle();
        halt   = 1'b0;
        branch = 1'b0;
        chk("br_beats_halt", 32'(halted1), 32'd0);
        cycle();
        chk("br_beats_halt_pc", instr_pc1, 32'h0000_0080);

        // Reset mid-stream with a read in flight.
        repeat (3) cycle();
        reset_n = 1'b0;
        cycle();
        chk("mid_rst_valid", 32'(valid1), 32'd0);
        chk("mid_rst_instr", 32'(instr1), 32'd0);
        chk("mid_rst_pc", instr_pc1, 32'd0);
        chk("mid_rst_mem_pc", mem_pc1, R1);
        reset_n = 1'b1;
        repeat (3) cycle();
        chk("post_rst_valid", 32'(valid1), 32'd1);
        chk("post_rst_pc", instr_pc1, R1);

        // Randomized traffic.
        repeat (600) begin
            int unsigned r;
            r      = $urandom_range(0, 99);
            ready1 = ($urandom_range(0, 9) < 7);
            branch = (r < 4);
            halt   = (r >= 4) && (r < 9);
            target = $urandom;
            cycle();
            chk("rnd_halted", 32'(halted1), 32'(mh));
            if (brp) chk("rnd_br_valid", 32'(valid1), 32'd0);
        end
        branch = 1'b0;
        halt   = 1'b0;
        repeat (4) cycle();
        chk("dut2_progress", 32'(pops2 > 20), 32'd1);
        chk("dut2_halted", 32'(halted2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_ctrl.md
# instruction_fetch_ctrl

- Sequences the program counter into the synchronous-read instruction memory (one-cycle read latency, halfword Thumb instructions).
- Tracks the single in-flight read and buffers returned instructions in a small FIFO, presenting them to decode with a valid/ready handshake.
- Handles branch redirects (flush plus kill of the in-flight read) and halt.
- Sits between the instruction memory and the decode stage.

## Interface
Parameters:
- DEPTH, 2, output FIFO entries; must be ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- mem_pc_o  out  WORD  address to instruction memory program counter input.
- mem_instr_i  in  HALF_WORD  instruction memory output; valid one cycle after the address is presented.
- instr_o  out  HALF_WORD  FIFO head instruction.
- instr_pc_o  out  WORD  address of instr_o.
- instr_valid_o  out  1  FIFO non-empty and state not RESET.
- decode_ready_i  in  1  decode accepts the head; a pop occurs when valid and ready are both high.
- branch_valid_i  in  1  redirect request, one cycle.
- branch_target_i  in  WORD  redirect address; bit 0 forced to 0.
- halt_i  in  1  stop issuing new fetches.
- halted_o  out  1  state is HALTED.

## Operation
- FSM states:
  - RESET: entered while reset_n_i=0. Goes to RUN on the first edge with reset_n_i=1.
  - RUN: issues fetches.
  - HALTED: no issues; the FIFO still drains.
- Transitions:
  - RUN→HALTED on halt_i=1 with branch_valid_i=0.
  - HALTED→RUN on branch_valid_i=1.
  - halt_i is ignored in HALTED and RESET.
- Issue rule (RUN only): issue in a cycle iff count − pop + inflight < DEPTH. count is the FIFO occupancy; inflight is the 1-bit flag marking an outstanding read.
  - The issued address is fetch_pc. Next fetch_pc = fetch_pc + 2, modulo 2^32 (wraps from 32'hFFFF_FFFE to 0).
  - The inflight flag and the in-flight PC are set at the issue edge.
- Response: with inflight=1, mem_instr_i and the in-flight PC are written to the FIFO tail at the next edge, unless killed. inflight then clears, or re-sets if a new issue occurs the same cycle.
- Branch (branch_valid_i=1, any state except RESET):
  - The FIFO is flushed, and any pop in the same cycle is ignored.
  - The in-flight response is discarded.
  - The target is issued in the same cycle: mem_pc_o = target & ~1. fetch_pc becomes target + 2, inflight=1, state=RUN.
  - Branch has priority over halt_i, pop and the normal issue.
- mem_pc_o when not issuing: holds the last issued address. Its value is don't-care to memory because the read is not tracked.
- Reset (synchronous, including mid-operation): fetch_pc=RESET_PC, count=0, inflight=0, state=RESET. Any in-flight response is dropped.
- Reset values of outputs: mem_pc_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, halted_o=0.
- FIFO full with the response arriving cannot occur by construction of the issue rule. An assertion covers this.

## Timing
- Cold start: reset released at edge E0.
  - Cycle after E0: RUN; RESET_PC is issued.
  - Edge E1: memory registers the data.
  - Edge E2: data enters the FIFO; instr_valid_o=1 in the cycle after E2.
- Sustained throughput with decode_ready_i=1: one instruction per cycle. PCs are consecutive +2.
- decode_ready_i low: at most DEPTH instructions are held. No loss and no duplication when ready returns.
- Branch asserted in cycle T:
  - instr_valid_o=0 in T+1.
  - The target instruction is valid in T+2 with instr_pc_o=target.
- Halt in cycle T: no issue from T onward. A read issued before T still completes into the FIFO.
- instr_o and instr_pc_o are stable while instr_valid_o=1 and decode_ready_i=0.

## Structure
- GENERAL_DEFS.svh provides WORD and HALF_WORD.
- Add to GENERAL_DEFS.svh: the fetch_state_t enum (RESET, RUN, HALTED) and the FETCH_RESET_PC constant.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of {pc, instr}.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push and pop.
- The controller holds the FSM, fetch_pc, the inflight flag and the in-flight PC, and the issue logic.

## Test plan
- Reset release with RESET_PC=0 and memory holding 0x1111, 0x2222, 0x3333, ready=1 → valid from the second cycle after release; outputs 0x1111/0, 0x2222/2, 0x3333/4 on consecutive cycles.
- Ready low for 5 cycles mid-stream → at most 2 buffered, no further mem issues; after ready rises, the sequence continues with no gap, repeat or drop.
- Branch to 0x0101 in cycle T while the FIFO holds 2 entries and one read is in flight → valid=0 in T+1; instr_pc_o=0x0100 in T+2; no stale instruction is ever presented.
- Branch and pop in the same cycle with the FIFO full → flush wins; the next presented PC is the target.
- halt_i in RUN → halted_o=1 next cycle; the FIFO drains; no new addresses are issued. A branch to 0x40 then resumes with 0x40 valid 2 cycles later.
- Wrap test: RESET_PC=32'hFFFF_FFFC → PCs FFFF_FFFC, FFFF_FFFE, 0000_0000.
- Reset asserted mid-stream with a read in flight → next cycle valid=0 and count=0; the stale response never appears after release.
